// File: rtl/move_collector_pkg.sv
// Shared chess definitions for the move collector: move layout, flag bits, FSM states.
package move_collector_pkg;

  localparam int NSQ   = 64;
  localparam int MW    = 19;
  localparam int SLOTS = 8;

  // Flag bit positions within the 7-bit flag field at the top of a move word
  localparam int FLAG_LSB      = 12;
  localparam int FLAG_INVALID  = 6;
  localparam int FLAG_PROMOTE  = 5;
  localparam int FLAG_PAWN     = 4;
  localparam int FLAG_PAWN2    = 3;
  localparam int FLAG_EP       = 2;
  localparam int FLAG_CASTLE   = 1;
  localparam int FLAG_CAPTURE  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_POP,
    ST_LATCH,
    ST_EMIT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/move_collector_slot_unpacker.sv
// Holds one FIFO word and walks its eight move slots from 7 down to 0.
module slot_unpacker
  import move_collector_pkg::*;
#(
  parameter int MW = move_collector_pkg::MW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [SLOTS*MW-1:0]   word_in,
  output logic [MW-1:0]         slot,
  output logic                  slot_valid,
  output logic                  last
);

  logic [SLOTS*MW-1:0] word;
  logic [2:0]          ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word <= '0;
      ptr  <= '0;
    end else if (load) begin
      word <= word_in;
      ptr  <= 3'd7;
    end else if (advance) begin
      ptr  <= ptr - 3'd1;
    end
  end

  always_comb begin
    slot       = word[ptr*MW +: MW];
    slot_valid = !slot[FLAG_LSB + FLAG_INVALID];
    last       = (ptr == 3'd0);
  end

endmodule

// File: rtl/move_collector.sv
// Collects generated moves from 64 square-unit FIFOs and streams them to the consumer.
// Optional done-wait watchdog: define MOVE_COLLECTOR_WATCHDOG_EN.
module move_collector
  import move_collector_pkg::*;
#(
  parameter int NSQ = move_collector_pkg::NSQ,
  parameter int FW  = 160,
  parameter int MW  = move_collector_pkg::MW,
  parameter int TMO = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NSQ-1:0]      sq_done,
  input  logic [NSQ-1:0]      sq_empty,
  input  logic [NSQ*FW-1:0]   sq_q,
  output logic [NSQ-1:0]      sq_rden,
  output logic [MW-1:0]       mv_data,
  output logic                mv_valid,
  input  logic                mv_ready,
  output logic                list_done,
  output logic [8:0]          mv_count,
  output logic                busy,
  output logic                timeout
);

  localparam int IW = $clog2(NSQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [MW-1:0]   slot;
  logic            slot_valid, slot_last;
  logic            load, advance, accept, wd_fire;

  slot_unpacker #(.MW(MW)) u_unpack (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (advance),
    .word_in    (sq_q[FW*idx +: SLOTS*MW]),
    .slot       (slot),
    .slot_valid (slot_valid),
    .last       (slot_last)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_WAIT;
      ST_WAIT:  if ((&sq_done) || wd_fire) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!sq_empty[idx])              state_nxt = ST_POP;
        else if (idx == IW'(NSQ - 1))    state_nxt = ST_FIN;
      end
      ST_POP:   state_nxt = ST_LATCH;
      ST_LATCH: begin
        load      = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        // Invalid slots drop through in one cycle; valid ones wait for the handshake
        if (!slot_valid || mv_ready) begin
          advance = 1'b1;
          if (slot_last) state_nxt = ST_SCAN;
        end
      end
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sq_rden = '0;
    if (state == ST_POP) sq_rden[idx] = 1'b1;
    mv_valid  = (state == ST_EMIT) && slot_valid;
    mv_data   = mv_valid ? slot : '0;
    list_done = (state == ST_FIN);
    busy      = (state != ST_IDLE) && (state != ST_FIN);
    accept    = mv_valid && mv_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      mv_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) mv_count <= '0;
      if (state == ST_WAIT) begin
        idx      <= '0;
        mv_count <= '0;
      end
      if (state == ST_SCAN && sq_empty[idx] && idx != IW'(NSQ - 1)) idx <= idx + 1'b1;
      if (accept && mv_count != '1) mv_count <= mv_count + 1'b1;
    end
  end

`ifdef MOVE_COLLECTOR_WATCHDOG_EN
  logic [7:0] wd_cnt;

  assign wd_fire = (state == ST_WAIT) && !(&sq_done) && (wd_cnt == 8'(TMO));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (wd_fire) timeout <= 1'b1;
      else         wd_cnt  <= wd_cnt + 8'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
